// File: rtl/oam_dma.sv
// OAM sprite DMA: a CPU write to $4014 stalls the CPU and copies page {reg_data,00..ff} to $2004.
// Build option OAM_DMA_ALIGN_EN adds an ALIGN cycle so that every READ falls on a get cycle.
module oam_dma (
   input  logic        clk4,
   input  logic        n_reset,
   input  logic        cyc_en,
   input  logic        reg_wr,
   input  logic [7:0]  reg_data,
   input  logic        cpu_rw,
   input  logic [7:0]  data_in,
   output logic        rdy,
   output logic        active,
   output logic [15:0] addr,
   output logic [7:0]  data_out,
   output logic        rw
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic        parity_q, parity_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  data_d;
   logic        rdy_d, active_d, rw_d;
   logic [15:0] addr_d;

   // Next-state, page/count and latched-byte logic for the bus cycle now ending.
   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      cnt_d    = cnt_q;
      data_d   = data_out;
      parity_d = ~parity_q;
      case (state_q)
         IDLE: begin
            if (reg_wr) begin
               page_d  = reg_data;
               cnt_d   = 8'h00;
               state_d = HALT;
            end else begin
               state_d = IDLE;
            end
         end
         HALT: begin
            // A CPU write cycle cannot be stalled, so wait for a read cycle.
            if (cpu_rw) begin
`ifdef OAM_DMA_ALIGN_EN
               // parity_q=1 means the cycle about to start is a get cycle.
               if (parity_q) begin
                  state_d = READ;
               end else begin
                  state_d = ALIGN;
               end
`else
               state_d = READ;
`endif
            end else begin
               state_d = HALT;
            end
         end
`ifdef OAM_DMA_ALIGN_EN
         ALIGN: begin
            state_d = READ;
         end
`endif
         READ: begin
            data_d  = data_in;
            state_d = WRITE;
         end
         WRITE: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'hff) begin
               state_d = IDLE;
            end else begin
               state_d = READ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Bus outputs for the cycle about to start, decoded from its state.
   always_comb begin
      active_d = 1'b0;
      rw_d     = 1'b1;
      addr_d   = 16'h0000;
      case (state_d)
         READ: begin
            active_d = 1'b1;
            rw_d     = 1'b1;
            addr_d   = {page_d, cnt_d};
         end
         WRITE: begin
            active_d = 1'b1;
            rw_d     = 1'b0;
            addr_d   = 16'h2004;
         end
         default: begin
            active_d = 1'b0;
            rw_d     = 1'b1;
            addr_d   = 16'h0000;
         end
      endcase
      if (state_d == IDLE) begin
         rdy_d = 1'b1;
      end else begin
         rdy_d = 1'b0;
      end
   end

   // All state and outputs move only on bus-cycle boundaries.
   always_ff @(posedge clk4 or negedge n_reset) begin
      if (!n_reset) begin
         state_q  <= IDLE;
         parity_q <= 1'b0;
         page_q   <= 8'h00;
         cnt_q    <= 8'h00;
         data_out <= 8'h00;
         addr     <= 16'h0000;
         rw       <= 1'b1;
         active   <= 1'b0;
         rdy      <= 1'b1;
      end else if (cyc_en) begin
         state_q  <= state_d;
         parity_q <= parity_d;
         page_q   <= page_d;
         cnt_q    <= cnt_d;
         data_out <= data_d;
         addr     <= addr_d;
         rw       <= rw_d;
         active   <= active_d;
         rdy      <= rdy_d;
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a short vector table, then transfers checked against a cycle-schedule model.
module tb_oam_dma;

   logic        clk4 = 1'b0;
   logic        n_reset;
   logic        cyc_en;
   logic        reg_wr;
   logic [7:0]  reg_data;
   logic        cpu_rw;
   logic [7:0]  data_in;
   logic        rdy;
   logic        active;
   logic [15:0] addr;
   logic [7:0]  data_out;
   logic        rw;

   logic [7:0]  mem [0:65535];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc_k = 0;

   typedef struct {
      logic        e_rdy;
      logic        e_act;
      logic        e_rw;
      logic [15:0] e_addr;
      logic        chk_addr;
      logic [7:0]  e_data;
      logic        chk_data;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [7:0]  d;
      logic        crw;
      exp_t        e;
   } tvec_t;

   oam_dma dut (
      .clk4     (clk4),
      .n_reset  (n_reset),
      .cyc_en   (cyc_en),
      .reg_wr   (reg_wr),
      .reg_data (reg_data),
      .cpu_rw   (cpu_rw),
      .data_in  (data_in),
      .rdy      (rdy),
      .active   (active),
      .addr     (addr),
      .data_out (data_out),
      .rw       (rw)
   );

   always #5 clk4 = ~clk4;

   // Memory answers whatever address the bus presents.
   assign data_in = mem[addr];

   task automatic check_out(input string name, input exp_t e);
      logic ok;
      ok = (rdy === e.e_rdy) && (active === e.e_act) && (rw === e.e_rw) &&
           (!e.chk_addr || (addr === e.e_addr)) && (!e.chk_data || (data_out === e.e_data));
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s cyc=%0d: got rdy=%b active=%b rw=%b addr=%h data_out=%h; want rdy=%b active=%b rw=%b addr=%h(chk %b) data_out=%h(chk %b)",
                  name, cyc_k, rdy, active, rw, addr, data_out,
                  e.e_rdy, e.e_act, e.e_rw, e.e_addr, e.chk_addr, e.e_data, e.chk_data);
      end
   endtask

   // One bus cycle: random idle clocks (cyc_en=0, noisy inputs), then the cyc_en edge.
   task automatic bus_cycle(input logic wr, input logic [7:0] d, input logic crw);
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
         @(negedge clk4);
         cyc_en   = 1'b0;
         reg_wr   = 1'($urandom_range(0, 1));
         reg_data = 8'($urandom);
         cpu_rw   = 1'($urandom_range(0, 1));
      end
      @(negedge clk4);
      cyc_en   = 1'b1;
      reg_wr   = wr;
      reg_data = d;
      cpu_rw   = crw;
      @(posedge clk4);
      #1;
      cyc_en = 1'b0;
      reg_wr = 1'b0;
      cyc_k++;
   endtask

   task automatic idle_cycles(input int n);
      exp_t e;
      e = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h00, 1'b0};
      for (int i = 0; i < n; i++) begin
         bus_cycle(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
         check_out("idle", e);
      end
   endtask

   // Asynchronous reset asserted between clock edges and checked before the next edge.
   task automatic do_reset();
      exp_t e;
      e = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h00, 1'b1};
      @(negedge clk4);
      #2;
      n_reset = 1'b0;
      #1;
      check_out("reset", e);
      repeat (2) @(negedge clk4);
      n_reset = 1'b1;
      cyc_k   = 0;
   endtask

   // Reference model: schedule of the whole transfer derived from the cycle index arithmetic.
   task automatic run_transfer(input logic [7:0] page, input int want_par, input int h,
                               input int stray_idx, input int abort_pair);
      exp_t q[$];
      int   k0;
      int   al;
      int   n_stall;
      int   seen_low;
      logic w;
      logic [7:0] d;
      logic c;
      while ((cyc_k % 2) != want_par) begin
         idle_cycles(1);
      end
      k0 = cyc_k;
      al = 0;
`ifdef OAM_DMA_ALIGN_EN
      if (((k0 + h + 2) % 2) == 1) al = 1;
`endif
      for (int i = 0; i <= h; i++) q.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0});
      if (al == 1) q.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h00, 1'b0});
      for (int i = 0; i < 256; i++) begin
         q.push_back('{1'b0, 1'b1, 1'b1, {page, 8'(i)}, 1'b1, 8'h00, 1'b0});
         q.push_back('{1'b0, 1'b1, 1'b0, 16'h2004, 1'b1, mem[{page, 8'(i)}], 1'b1});
      end
      q.push_back('{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h00, 1'b0});
      n_stall  = h + 1 + al + 512;
      seen_low = 0;
      for (int idx = 0; idx < q.size(); idx++) begin
         if (abort_pair >= 0 && (idx - 1) == (h + 1 + al + 2 * abort_pair)) begin
            do_reset();
            idle_cycles(4);
            return;
         end
         if (idx == 0) begin
            w = 1'b1;
            d = page;
            c = 1'b0;
         end else begin
            w = ((idx - 1) == stray_idx);
            d = w ? 8'h07 : 8'($urandom);
            if ((idx - 1) < h) c = 1'b0;
            else if ((idx - 1) == h) c = 1'b1;
            else c = 1'($urandom_range(0, 1));
         end
         bus_cycle(w, d, c);
         check_out("xfer", q[idx]);
         if (rdy === 1'b0) seen_low++;
      end
      n_cmp++;
      if (seen_low != n_stall) begin
         n_bad++;
         $display("FAIL stall_len page=%h: got %0d cycles, want %0d", page, seen_low, n_stall);
      end
      idle_cycles(1);
   endtask

   initial begin
      tvec_t tv [5];
      n_reset  = 1'b0;
      cyc_en   = 1'b0;
      reg_wr   = 1'b0;
      reg_data = 8'h00;
      cpu_rw   = 1'b1;
      for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'h5a;

      tv[0] = '{1'b1, 8'h02, 1'b0, '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0}};
      tv[1] = '{1'b0, 8'h33, 1'b1, '{1'b0, 1'b1, 1'b1, 16'h0200, 1'b1, 8'h00, 1'b0}};
      tv[2] = '{1'b1, 8'h07, 1'b0, '{1'b0, 1'b1, 1'b0, 16'h2004, 1'b1, 8'h5a, 1'b1}};
      tv[3] = '{1'b0, 8'h00, 1'b1, '{1'b0, 1'b1, 1'b1, 16'h0201, 1'b1, 8'h00, 1'b0}};
      tv[4] = '{1'b1, 8'h09, 1'b1, '{1'b0, 1'b1, 1'b0, 16'h2004, 1'b1, 8'h5b, 1'b1}};

      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus_cycle(tv[i].wr, tv[i].d, tv[i].crw);
         check_out("table", tv[i].e);
      end
      do_reset();
      idle_cycles(3);

      run_transfer(8'h02, 0, 0, -1, -1);
      run_transfer(8'h02, 1, 0, -1, -1);
      run_transfer(8'h02, 0, 2, -1, -1);
      run_transfer(8'h03, 1, 1, -1, -1);
      run_transfer(8'h02, 0, 0, -1, 100);
      run_transfer(8'h04, 0, 0, -1, -1);
      run_transfer(8'h02, 1, 0, 101, -1);
      run_transfer(8'hff, 1, 1, 300, -1);

      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
         run_transfer(8'($urandom), $urandom_range(0, 1), $urandom_range(0, 3),
                      $urandom_range(0, 511), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL have ports: clk4  in  1  system clock, all state on rising edge.
REQ-002 The block SHALL have ports: n_reset  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have ports: cyc_en  in  1  one-clk4 pulse marking the boundary between CPU bus cycles.
REQ-004 The block SHALL have ports: reg_wr  in  1  CPU write to $4014 during the cycle ending at this cyc_en.
REQ-005 The block SHALL have ports: reg_data  in  8  page byte written with reg_wr.
REQ-006 The block SHALL have ports: cpu_rw  in  1  CPU's rw for the current bus cycle.
REQ-007 The block SHALL have ports: data_in  in  8  bus read data, valid at the cyc_en that ends a read cycle.
REQ-008 The block SHALL have ports: rdy  out  1  CPU ready, 0 stalls the CPU.
REQ-009 The block SHALL have ports: active  out  1  1 while the block owns addr/data_out/rw.
REQ-010 The block SHALL have ports: addr  out  16  DMA bus address.
REQ-011 The block SHALL have ports: data_out  out  8  DMA write data.
REQ-012 The block SHALL have ports: rw  out  1  DMA bus direction, 1 read / 0 write.

Function
REQ-013 The block SHALL advance state, parity and outputs only on clk4 edges where cyc_en=1; each bus cycle lasts from one cyc_en to the next.
REQ-014 The parity flop SHALL toggle on every cyc_en; a cycle with parity=0 is a "get" cycle, and parity=1 is a "put" cycle.
REQ-015 The state machine SHALL use the states IDLE, HALT, ALIGN, READ and WRITE.
REQ-016 In IDLE, reg_wr=1 at cyc_en SHALL latch page=reg_data, clear cnt to 0, enter HALT and drive rdy=0.
REQ-017 In HALT, if cpu_rw=1 at cyc_en, the block SHALL leave HALT: to READ if the next cycle is a get cycle, otherwise to ALIGN.
REQ-018 In HALT, if cpu_rw=0 at cyc_en, the block SHALL remain in HALT, because a CPU write cycle cannot be stalled.
REQ-019 ALIGN SHALL last one cycle with active=0, then enter READ.
REQ-020 In READ, outputs SHALL be active=1, rw=1 and addr={page,cnt}; at the ending cyc_en the block SHALL latch data_in into data_out and enter WRITE.
REQ-021 In WRITE, outputs SHALL be active=1, rw=0, addr=16'h2004 and data_out=the latched byte.
REQ-022 At the end of WRITE, cnt SHALL increment by 1 (8-bit); if cnt was 8'hff, the block SHALL enter IDLE, otherwise it SHALL enter READ.
REQ-023 Transfer length SHALL be 256 read/write pairs; with alignment the total stall is 513 cycles (even start) or 514 cycles (odd start).
REQ-024 rdy SHALL be 0 in HALT, ALIGN, READ and WRITE, and 1 in IDLE.
REQ-025 In IDLE and ALIGN, outputs SHALL be addr=0 and rw=1.
REQ-026 reg_wr SHALL be ignored in any state other than IDLE, with no restart and no page change.
REQ-027 rdy SHALL return to 1 on the same cyc_en edge that ends the final WRITE.
REQ-028 Page 8'hff SHALL read addresses 16'hff00 through 16'hffff without wrapping into the next page.

Reset
REQ-029 On n_reset=0, the block SHALL asynchronously force state=IDLE, parity=0, cnt=0, page=0, data_out=0, addr=0, rw=1, active=0 and rdy=1.
REQ-030 A reset during a transfer SHALL abort it immediately; after reset release, the block SHALL stay in IDLE until a new reg_wr.

Configuration
REQ-031 Macro OAM_DMA_ALIGN_EN defined: HALT exits to ALIGN on put cycles as in REQ-017, so every READ falls on a get cycle.
REQ-032 Macro OAM_DMA_ALIGN_EN undefined: there SHALL be no ALIGN state logic, HALT SHALL always exit to READ, and the stall SHALL be exactly 513 cycles regardless of parity.

Verification
REQ-033 Write page 8'h02 at an even (parity=0) cycle with cpu_rw=1 -> rdy low for 513 cycles; first READ addr=16'h0200; the 256th WRITE carries the byte from 16'h02ff.
REQ-034 Same write one cycle later (odd parity), OAM_DMA_ALIGN_EN defined -> one ALIGN cycle; 514 stall cycles. Same stimulus with the macro undefined -> 513 stall cycles.
REQ-035 Hold cpu_rw=0 for 2 cycles after reg_wr -> HALT persists for 3 cycles before the first READ; byte ordering is unchanged.
REQ-036 Memory filled with pattern mem[a]=a[7:0]^8'h5a, page 8'h03 -> the 256 writes to 16'h2004 carry 8'h5a, 8'h5b, ..., 8'ha5 in order.
REQ-037 Pulse n_reset low at pair 100, then issue reg_wr page 8'h04 -> the block idles with rdy=1 after reset, and the restart begins at 16'h0400.
REQ-038 Pulse reg_wr with page 8'h07 mid-transfer of page 8'h02 -> ignored; all remaining reads stay in 16'h02xx.
